// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding, stage sizes and Q10.10 bias constants for the decoder
package decoder_pkg;
  typedef enum logic [3:0] {
    IDLE, FEED_P, WAIT_1, FEED_1, WAIT_2, FEED_2, WAIT_3, FEED_3, WAIT_D, DONE
  } state_t;
  localparam int DEF_N_PARAM = 2;
  localparam int DEF_N_L1 = 50;
  localparam int DEF_N_L2 = 100;
  localparam int DEF_N_L3 = 900;
  localparam int Q_INT_W = 10;
  localparam int Q_FRAC_W = 10;
  localparam int Q_W = Q_INT_W + Q_FRAC_W;
  localparam logic [Q_W-1:0] DEF_L3_BIAS = 20'h00CF1;
  localparam logic [Q_W-1:0] DEF_L4_BIAS = 20'h007DD;
  function automatic logic is_feed(input state_t s);
    return s inside {FEED_P, FEED_1, FEED_2, FEED_3};
  endfunction
endpackage

// File: rtl/decoder_stage_sequencer_stream_feeder.sv
// stream_feeder: shared sweep counter producing upstream address and latency-aligned downstream enable
module stream_feeder #(
  parameter int ADDR_W = 13,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] n,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              last
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAT = ADDR_W'(READ_LAT);
  localparam logic [ADDR_W-1:0] LAT_M1 = ADDR_W'(READ_LAT - 1);
  logic [ADDR_W-1:0] cnt;
  // counter idles at 0 outside a sweep, so every sweep starts from a clean count
  assign last = run && cnt == n + LAT_M1;
  assign addr = cnt < n ? cnt : n - ONE;
  assign en = cnt >= LAT && cnt < n + LAT;
  always_ff @(posedge clk)
    if (!reset || !run || last) cnt <= '0;
    else cnt <= cnt + ONE;
endmodule

// File: rtl/decoder_stage_sequencer.sv
// decoder_stage_sequencer: one FSM sequencing the four decoder stage handoffs through a shared feeder
module decoder_stage_sequencer
  import decoder_pkg::*;
#(
  parameter int N_PARAM = DEF_N_PARAM,
  parameter int N_L1 = DEF_N_L1,
  parameter int N_L2 = DEF_N_L2,
  parameter int N_L3 = DEF_N_L3,
  parameter int READ_LAT = 1,
  parameter int ADDR_W = 13,
  parameter int DATA_W = Q_W,
  parameter logic [DATA_W-1:0] L3_BIAS = DEF_L3_BIAS,
  parameter logic [DATA_W-1:0] L4_BIAS = DEF_L4_BIAS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              l1_done,
  input  logic              l2_done,
  input  logic              l3_done,
  input  logic              dec_done,
  output logic [ADDR_W-1:0] param_addr,
  output logic [ADDR_W-1:0] l1_addr,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [ADDR_W-1:0] l3_addr,
  output logic              l1_rd_en,
  output logic              l2_rd_en,
  output logic              l3_rd_en,
  output logic              l4_rd_en,
  output logic [DATA_W-1:0] l3_bias,
  output logic [DATA_W-1:0] l4_bias,
  output logic              busy,
  output logic [3:0]        stage,
  output logic              seq_done
);
  state_t state, next;
  logic [ADDR_W-1:0] n_sel, f_addr;
  logic f_en, f_last;
  assign n_sel = state == FEED_1 ? ADDR_W'(N_L1) :
                 state == FEED_2 ? ADDR_W'(N_L2) :
                 state == FEED_3 ? ADDR_W'(N_L3) : ADDR_W'(N_PARAM);
  stream_feeder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) u_feeder (
    .clk(clk), .reset(reset), .run(is_feed(state)), .n(n_sel),
    .addr(f_addr), .en(f_en), .last(f_last)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:   next = start ? FEED_P : IDLE;
      FEED_P: next = f_last ? WAIT_1 : FEED_P;
      WAIT_1: next = l1_done ? FEED_1 : WAIT_1;
      FEED_1: next = f_last ? WAIT_2 : FEED_1;
      WAIT_2: next = l2_done ? FEED_2 : WAIT_2;
      FEED_2: next = f_last ? WAIT_3 : FEED_2;
      WAIT_3: next = l3_done ? FEED_3 : WAIT_3;
      FEED_3: next = f_last ? WAIT_D : FEED_3;
      WAIT_D: next = dec_done ? DONE : WAIT_D;
      DONE:   next = start ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      l3_bias <= '0;
      l4_bias <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) l3_bias <= '0;
      if (state == IDLE && start) l4_bias <= '0;
      if (state == WAIT_2 && l2_done) l3_bias <= L3_BIAS;
      if (state == WAIT_3 && l3_done) l4_bias <= L4_BIAS;
    end
  // only the handoff owning the current FEED state sees the feeder
  assign param_addr = state == FEED_P ? f_addr : '0;
  assign l1_addr = state == FEED_1 ? f_addr : '0;
  assign l2_addr = state == FEED_2 ? f_addr : '0;
  assign l3_addr = state == FEED_3 ? f_addr : '0;
  assign l1_rd_en = state == FEED_P && f_en;
  assign l2_rd_en = state == FEED_1 && f_en;
  assign l3_rd_en = state == FEED_2 && f_en;
  assign l4_rd_en = state == FEED_3 && f_en;
  assign busy = state != IDLE && state != DONE;
  assign seq_done = state == DONE;
  assign stage = state;
endmodule
